// File: rtl/drone_call_dispatcher_pkg.sv
// Shared types and constants for the drone call dispatcher: FSM encoding,
// floor indices and the floor-to-Call one-hot mapping.
package drone_call_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_DROP = 2'b01,
        COOLDOWN  = 2'b10
    } state_t;

    localparam int FLOOR5 = 0;
    localparam int FLOOR6 = 1;

    function automatic logic [1:0] floor_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/drone_call_dispatcher_pend.sv
// Per-floor pending-request counter: saturating up/down with a sticky
// overflow flag raised when an increment is lost at full scale.
module pend_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // Simultaneous increment and decrement cancel, even at full scale.
        if (inc_i && !dec_i) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/drone_call_dispatcher.sv
// Floor-side dispatcher: counts button presses on floors 5/6, drives one
// Call line at a time with round-robin fairness and retries on timeout.
module drone_call_dispatcher
    import drone_call_dispatcher_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = 15,
    parameter int TMR_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_btn,
    input  logic [1:0]       drop,
    input  logic             bird,
    output logic [1:0]       call,
    output logic [CNT_W-1:0] pend5,
    output logic [CNT_W-1:0] pend6,
    output logic             busy,
    output logic             timeout_err,
    output logic             ovf
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = 1;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic [1:0]       call_q, call_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             terr_q, terr_d;
    logic [1:0]       btn_q, drop_q;
    logic [1:0]       press, ack, serve_done;
    logic             ovf5, ovf6;

    assign press = req_btn & ~btn_q;
    assign ack   = drop & ~drop_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        call_d     = call_q;
        timer_d    = timer_q;
        terr_d     = 1'b0;
        serve_done = 2'b00;
        case (state_q)
            IDLE: begin
                if (pend5 != '0 || pend6 != '0) begin
                    sel_d   = (pend5 != '0 && pend6 != '0) ? rr_q : (pend5 == '0);
                    call_d  = floor_onehot(sel_d);
                    timer_d = '0;
                    state_d = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                // An acknowledge on the selected floor beats a same-cycle timeout.
                if (ack[sel_q]) begin
                    serve_done = floor_onehot(sel_q);
                    call_d     = 2'b00;
                    rr_d       = ~sel_q;
                    state_d    = COOLDOWN;
                end else if (!bird) begin
                    if (timer_q == TMR_LAST) begin
                        call_d  = 2'b00;
                        terr_d  = 1'b1;
                        rr_d    = ~sel_q;
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
            end
            COOLDOWN: begin
                call_d  = 2'b00;
                state_d = IDLE;
            end
            default: begin
                call_d  = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            call_q  <= 2'b00;
            timer_q <= '0;
            terr_q  <= 1'b0;
            btn_q   <= 2'b00;
            drop_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            call_q  <= call_d;
            timer_q <= timer_d;
            terr_q  <= terr_d;
            btn_q   <= req_btn;
            drop_q  <= drop;
        end
    end

    pend_counter #(.CNT_W(CNT_W)) u_pend5 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (press[FLOOR5]),
        .dec_i (serve_done[FLOOR5]),
        .cnt_o (pend5),
        .ovf_o (ovf5)
    );

    pend_counter #(.CNT_W(CNT_W)) u_pend6 (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (press[FLOOR6]),
        .dec_i (serve_done[FLOOR6]),
        .cnt_o (pend6),
        .ovf_o (ovf6)
    );

    assign call        = call_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = terr_q;
    assign ovf         = ovf5 | ovf6;

endmodule

// File: doc/drone_call_dispatcher.md
Name: drone_call_dispatcher

Overview:
Floor-side counterpart of the drone delivery controller: it originates the Call[1:0] requests the controller consumes and closes each request on the controller's Drop[1:0] acknowledge. It latches package-request button presses on floors 5 and 6, keeps a pending count per floor, and serves one floor at a time with round-robin fairness. A timeout re-queues a request the drone never completes. It sits between the floor button panels and the controller's Call/Drop pins.

Parameters:
CNT_W, 3, width of each per-floor pending counter; saturates at 2^CNT_W-1
TIMEOUT, 15, WAIT_DROP cycles (bird low) before the request is abandoned and re-queued
TMR_W, 4, timeout counter width; must satisfy TIMEOUT <= 2^TMR_W-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req_btn  in  2  raw request buttons; bit0 = floor 5, bit1 = floor 6; level, held for any number of cycles
drop  in  2  Drop[1:0] from the controller; bit0 = floor 5 drop, bit1 = floor 6 drop
bird  in  1  bird emergency; freezes the timeout counter while high
call  out  2  Call[1:0] to the controller; one-hot or zero, registered
pend5  out  CNT_W  pending requests, floor 5
pend6  out  CNT_W  pending requests, floor 6
busy  out  1  high in WAIT_DROP and COOLDOWN
timeout_err  out  1  one-cycle pulse when a request times out
ovf  out  1  sticky: a press was lost to saturation; cleared only by reset

Behaviour:
- Reset (rst_n low at a clock edge) applies regardless of state, including mid-WAIT_DROP. After reset: call=00, pend5=pend6=0, busy=0, timeout_err=0, ovf=0, state=IDLE, timer=0, rr=0 (floor 5 preferred), btn_q=00, drop_q=00.
- Press detect: btn_q <= req_btn every cycle. press[i] = req_btn[i] & ~btn_q[i]. A press is counted once per rising level.
- Counters update at each edge as pend[i] + press[i] - serve_done[i]:
  - Press and serve_done on the same floor in the same cycle: net no change.
  - Increment at 2^CNT_W-1: hold the value and set ovf.
- Drop edge: drop_q <= drop. ack[i] = drop[i] & ~drop_q[i].
- FSM states: IDLE, WAIT_DROP, COOLDOWN.
- IDLE:
  - If pend5 = 0 and pend6 = 0, stay; call=00.
  - If both are nonzero, select floor rr (0 = floor 5, 1 = floor 6).
  - Otherwise select the nonzero floor.
  - Next edge: sel <= choice, call <= onehot(sel), timer <= 0, state <= WAIT_DROP.
  - A press on the cycle pend goes 0 -> 1 is seen by IDLE one cycle later, because IDLE reads registered pend.
- WAIT_DROP: call holds onehot(sel).
  - ack[sel]: serve_done[sel]=1, call <= 00, rr <= ~sel, state <= COOLDOWN.
  - Otherwise, if bird=0: timer increments. When timer = TIMEOUT-1 and no ack, then call <= 00, timeout_err pulses one cycle, rr <= ~sel, state <= IDLE. pend is unchanged, so the request is retried.
  - bird=1: timer holds.
  - ack on the non-selected floor is ignored; its counter is unaffected.
  - ack[sel] in the same cycle as the timeout: ack wins and there is no timeout_err.
- COOLDOWN: one cycle with call=00 so the controller sees Call fall, then IDLE.
- Latency:
  - Button first sampled high at edge k: pend updates at k.
  - call asserted after edge k+1.
  - Drop rising sampled at edge m: pend decrements and call clears at edge m.
  - Earliest next call: edge m+2.
- Outputs are all registered; there is no combinational path from input to output.

Decomposition:
- Shared package:
  - State encoding IDLE=2'b00, WAIT_DROP=2'b01, COOLDOWN=2'b10.
  - Floor index constants FLOOR5=0, FLOOR6=1.
- Sub-module pend_counter: saturating up/down counter with ovf output. Instantiate once per floor.

Test Plan:
1. Reset then idle: rst_n low 2 cycles, inputs 0 -> call=00, pend5=pend6=0, busy=0, ovf=0 for 10 cycles.
2. Single floor-5 request:
   - Stimulus: req_btn=01 for 3 cycles, then drop=01 raised 4 cycles after call rises.
   - Required: pend5=1 after the first edge; call=01 one edge later; on drop, pend5=0 and call=00; busy falls 2 edges after drop.
3. Round-robin:
   - Stimulus: press floor 5 twice and floor 6 once before IDLE samples; ack each call.
   - Required: call order 01, 10, 01; pend5 ends at 0 and pend6 at 0.
4. Timeout with bird:
   - Stimulus: one floor-6 request, no drop; bird=1 for 5 cycles mid-wait.
   - Required: timeout_err pulses exactly TIMEOUT+5 cycles after call=10 rises; pend6 stays 1; call re-asserts 10 one cycle after the timeout.
5. Saturation and simultaneous events:
   - Stimulus: 8 floor-5 presses with CNT_W=3.
   - Required: pend5=7, ovf=1. A press on the same cycle as drop ack leaves pend5 unchanged.
6. Reset mid-operation: rst_n low while in WAIT_DROP with pend6=2 -> next edge call=00, pend6=0, state IDLE, ovf=0.
